spi_arbiter: RTL

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_arbiter.sv
// Round-robin arbiter granting four requesters one at a time onto a shared SPI master.
// Grant to spi_start is one cycle; the SPI master's busy flag paces completion, with a per-wait-state timeout.
module spi_arbiter #(
    parameter int N_GAP   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic        spi_start,
    output logic [7:0]  spi_data,
    input  logic        spi_busy,
    output logic [1:0]  cs_sel,
    output logic        active,
    output logic        timeout_err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] WAIT_HI = 3'd2;
    localparam logic [2:0] WAIT_LO = 3'd3;
    localparam logic [2:0] GAP     = 3'd4;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (N_GAP > 1) ? $clog2(N_GAP) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(N_GAP - 1);

    logic [2:0]    state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [3:0]    done_q, done_d;
    logic [7:0]    data_q, data_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          err_q, err_d;

    logic          found;
    logic [1:0]    pick_idx;
    logic [1:0]    cand;
    logic          leave;

    // Round-robin search: first asserted req at or after ptr, wrapping 3->0.
    always_comb begin
        found    = 1'b0;
        pick_idx = ptr_q;
        cand     = ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && req[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        gnt_d     = gnt_q;
        done_d    = 4'b0000;
        data_d    = data_q;
        tmo_cnt_d = tmo_cnt_q;
        gap_cnt_d = gap_cnt_q;
        err_d     = err_q;
        leave     = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d   = pick_idx;
                    gnt_d   = 4'b0001 << pick_idx;
                    data_d  = req_data[{pick_idx, 3'b000} +: 8];
                    state_d = START;
                end
            end
            START: begin
                tmo_cnt_d = '0;
                state_d   = WAIT_HI;
            end
            WAIT_HI: begin
                if (spi_busy) begin
                    tmo_cnt_d = '0;
                    state_d   = WAIT_LO;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_d = 1'b1;
                    leave = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!spi_busy) begin
                    done_d = gnt_q;
                    leave  = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    err_d = 1'b1;
                    leave = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Normal completion and timeout abort share the same release path.
        if (leave) begin
            gnt_d     = 4'b0000;
            ptr_d     = idx_q + 2'd1;
            gap_cnt_d = '0;
            tmo_cnt_d = '0;
            state_d   = (N_GAP == 0) ? IDLE : GAP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            idx_q     <= 2'd0;
            gnt_q     <= 4'b0000;
            done_q    <= 4'b0000;
            data_q    <= 8'h00;
            tmo_cnt_q <= '0;
            gap_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            data_q    <= data_d;
            tmo_cnt_q <= tmo_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            err_q     <= err_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign spi_start   = (state_q == START);
    assign spi_data    = data_q;
    assign cs_sel      = idx_q;
    assign active      = (state_q != IDLE) && (state_q != GAP);
    assign timeout_err = err_q;

endmodule
